// File: rtl/axi_reg_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the register bank.
package axi_reg_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_reg_decode.sv
// Per-beat word-index decode: RW register, checksum slot, or error.
module axi_reg_decode
  import axi_reg_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 32,
  parameter int unsigned DEPTH     = 8
) (
  input  logic [IDX_WIDTH-1:0] index,
  input  logic [1:0]           burst,
  output logic                 is_reg,
  output logic                 is_csum,
  output logic                 err
);
  localparam logic [IDX_WIDTH-1:0] CSUM_IDX = IDX_WIDTH'(DEPTH);

  logic burst_ok;

  assign burst_ok = (burst == BURST_FIXED) || (burst == BURST_INCR);
  assign is_reg   = burst_ok && (index < CSUM_IDX);
  assign is_csum  = burst_ok && (index == CSUM_IDX);
  assign err      = !(is_reg || is_csum);
endmodule

// File: rtl/axi_reg_bank.sv
// Parametrised AXI4 slave register bank with FIXED/INCR bursts, checksum word
// at index DEPTH and a flat register image for fabric logic.
module axi_reg_bank
  import axi_reg_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH  = 32,
  parameter int unsigned     ADDR_WIDTH  = 32,
  parameter int unsigned     ID_WIDTH    = 4,
  parameter int unsigned     DEPTH       = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic [ID_WIDTH-1:0]         awid,
  input  logic [ADDR_WIDTH-1:0]       awaddr,
  input  logic [7:0]                  awlen,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [ID_WIDTH-1:0]         bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [ID_WIDTH-1:0]         arid,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic [7:0]                  arlen,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [ID_WIDTH-1:0]         rid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [DEPTH*DATA_WIDTH-1:0] regs_o
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(NB);
  localparam int unsigned RIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] csum;

  always_comb begin
    csum   = '0;
    regs_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      csum = csum ^ regs[k];
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end
  end

  // ---------------- write path ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_is_reg, w_is_csum, w_dec_err, w_final, w_beat;

  axi_reg_decode #(.IDX_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_wdec (
    .index(w_idx), .burst(w_burst),
    .is_reg(w_is_reg), .is_csum(w_is_csum), .err(w_dec_err)
  );

  assign w_final = (w_cnt == w_len);
  assign w_beat  = (w_state == W_DATA) && wvalid;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (awvalid)           w_next = W_DATA;
      W_DATA: if (wvalid && w_final) w_next = W_RESP;
      W_RESP: if (bready)            w_next = W_IDLE;
      default:                       w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bid     = w_id;
    bresp   = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if ((w_state == W_IDLE) && awvalid) begin
      w_id    <= awid;
      w_idx   <= awaddr >> SHIFT;
      w_len   <= awlen;
      w_cnt   <= '0;
      w_burst <= awburst;
      w_err   <= 1'b0;
    end else if (w_beat) begin
      // Checksum slot is read-only; wlast only flags, it never ends the burst.
      w_err <= w_err | w_dec_err | w_is_csum | (wlast != w_final);
      w_cnt <= w_cnt + 8'd1;
      if (w_burst == BURST_INCR) w_idx <= w_idx + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int unsigned k = 0; k < DEPTH; k++) regs[k] <= RESET_VALUE;
    end else if (w_beat && w_is_reg) begin
      for (int unsigned b = 0; b < NB; b++)
        if (wstrb[b]) regs[w_idx[RIW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_idx, ld_idx;
  logic [7:0]            r_len, r_cnt, ld_len, ld_cnt;
  logic [1:0]            r_burst, ld_burst;
  logic                  r_is_reg, r_is_csum, r_dec_err, ld_en;
  logic [DATA_WIDTH-1:0] ld_data;

  // One mux feeds both beat 0 (from AR) and follow-on beats (from latched state).
  always_comb begin
    if (r_state == R_IDLE) begin
      ld_idx   = araddr >> SHIFT;
      ld_burst = arburst;
      ld_len   = arlen;
      ld_cnt   = '0;
    end else begin
      ld_idx   = (r_burst == BURST_INCR) ? r_idx + ADDR_WIDTH'(1) : r_idx;
      ld_burst = r_burst;
      ld_len   = r_len;
      ld_cnt   = r_cnt + 8'd1;
    end
  end

  axi_reg_decode #(.IDX_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_rdec (
    .index(ld_idx), .burst(ld_burst),
    .is_reg(r_is_reg), .is_csum(r_is_csum), .err(r_dec_err)
  );

  always_comb begin
    ld_data = '0;
    if (r_is_reg)       ld_data = regs[ld_idx[RIW-1:0]];
    else if (r_is_csum) ld_data = csum;
  end

  assign ld_en = ((r_state == R_IDLE) && arvalid) ||
                 ((r_state == R_DATA) && rready && !rlast);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (arvalid)         r_next = R_DATA;
      R_DATA: if (rready && rlast) r_next = R_IDLE;
      default:                     r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rid     <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else if (ld_en) begin
      if (r_state == R_IDLE) rid <= arid;
      r_idx   <= ld_idx;
      r_len   <= ld_len;
      r_cnt   <= ld_cnt;
      r_burst <= ld_burst;
      rdata   <= ld_data;
      rresp   <= r_dec_err ? RESP_SLVERR : RESP_OKAY;
      rlast   <= (ld_cnt == ld_len);
    end else if ((r_state == R_DATA) && rready && rlast) begin
      rlast <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_reg_bank.sv
// Directed self-checking bench for axi_reg_bank (DEPTH=8, 32-bit data).
module tb_axi_reg_bank;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DP = 8;

  logic          clk, areset;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [DP*DW-1:0] regs_o;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] wbuf [16];
  logic [31:0] ed   [16];
  logic [1:0]  er   [16];

  axi_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DP),
                 .RESET_VALUE(32'h0)) dut (
    .clk(clk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .regs_o(regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return regs_o[k*DW +: DW];
  endfunction

  task automatic wr(input string tag, input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                    input bit bad_last, input logic [1:0] exp_resp);
    int to;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    to = 0;
    while (!awready && to < 50) begin @(negedge clk); to++; end
    check({tag, " aw_timeout"}, 64'(to < 50), 64'd1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    check({tag, " wready_lat"}, 64'(wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wvalid = 1'b1;
      wlast = bad_last ? 1'b0 : (i == int'(len));
      to = 0;
      while (!wready && to < 50) begin @(negedge clk); to++; end
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, " bvalid_lat"}, 64'(bvalid), 64'd1);
    check({tag, " bresp"}, 64'(bresp), 64'(exp_resp));
    check({tag, " bid"}, 64'(bid), 64'(id));
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst, input bit toggle);
    int to, beat;
    bit phase;
    logic [31:0] hd; logic [1:0] hr; logic hl;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    to = 0;
    while (!arready && to < 50) begin @(negedge clk); to++; end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check({tag, " rvalid_lat"}, 64'(rvalid), 64'd1);
    beat = 0; to = 0; phase = 1'b0;
    while (beat <= int'(len) && to < 200) begin
      rready = toggle ? phase : 1'b1;
      phase = !phase;
      if (rvalid && !rready) begin
        hd = rdata; hr = rresp; hl = rlast;
        @(posedge clk); @(negedge clk);
        check($sformatf("%s stall%0d", tag, beat), {29'd0, hl, hr, hd}, {29'd0, rlast, rresp, rdata});
      end else if (rvalid) begin
        check($sformatf("%s data%0d", tag, beat), 64'(rdata), 64'(ed[beat]));
        check($sformatf("%s resp%0d", tag, beat), 64'(rresp), 64'(er[beat]));
        check($sformatf("%s last%0d", tag, beat), 64'(rlast), 64'(beat == int'(len)));
        check($sformatf("%s rid%0d", tag, beat), 64'(rid), 64'(id));
        @(posedge clk); @(negedge clk);
        beat++;
      end else begin
        @(negedge clk);
      end
      to++;
    end
    rready = 1'b0;
    check({tag, " r_timeout"}, 64'(to < 200), 64'd1);
    check({tag, " r_done"}, 64'(rvalid), 64'd0);
  endtask

  initial begin
    areset = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst awready", 64'(awready), 64'd1);
    check("rst arready", 64'(arready), 64'd1);
    check("rst wready", 64'(wready), 64'd0);
    check("rst bvalid", 64'(bvalid), 64'd0);
    check("rst rvalid", 64'(rvalid), 64'd0);
    check("rst rlast", 64'(rlast), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    check("rst bid_rid", {56'd0, bid, rid}, 64'd0);
    check("rst regs", 64'(regs_o == '0), 64'd1);
    areset = 1'b1;

    // W data before AW is not accepted
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    check("early wready", 64'(wready), 64'd0);
    wvalid = 1'b0; wlast = 1'b0;

    // Single write/read
    wbuf[0] = 32'hDEAD_BEEF;
    wr("single", 4'd1, 32'h08, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
    ed[0] = 32'hDEAD_BEEF; er[0] = 2'b00;
    rd("single_rd", 4'd2, 32'h08, 8'd0, 2'b01, 1'b0);

    // Partial strobe
    wbuf[0] = 32'h1122_3344;
    wr("strb_full", 4'd0, 32'h04, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
    wbuf[0] = 32'hAABB_CCDD;
    wr("strb_part", 4'd0, 32'h04, 8'd0, 2'b01, 4'h5, 1'b0, 2'b00);
    ed[0] = 32'h11BB_33DD; er[0] = 2'b00;
    rd("strb_rd", 4'd0, 32'h04, 8'd0, 2'b01, 1'b0);

    // Clear to a known image
    @(negedge clk); areset = 1'b0;
    @(negedge clk); areset = 1'b1;

    // INCR write burst running into the checksum slot
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    wr("incr_wr", 4'd5, 32'h14, 8'd3, 2'b01, 4'hF, 1'b0, 2'b10);
    check("incr reg5", 64'(reg_of(5)), 64'd1);
    check("incr reg6", 64'(reg_of(6)), 64'd2);
    check("incr reg7", 64'(reg_of(7)), 64'd3);
    ed[0] = 32'd0; er[0] = 2'b00;
    rd("csum_rd", 4'd0, 32'h20, 8'd0, 2'b01, 1'b0);

    // INCR read burst with rready toggling, crossing checksum and beyond
    wbuf[0] = 32'h1234_5678;
    wr("reg0", 4'd0, 32'h00, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
    ed[0] = 32'h1234_5678; ed[1] = 0; ed[2] = 0; ed[3] = 0; ed[4] = 0;
    ed[5] = 1; ed[6] = 2; ed[7] = 3; ed[8] = 32'h1234_5678; ed[9] = 0;
    for (int i = 0; i < 9; i++) er[i] = 2'b00;
    er[9] = 2'b10;
    rd("burst_rd", 4'd7, 32'h00, 8'd9, 2'b01, 1'b1);

    // FIXED burst holds the index
    wbuf[0] = 32'h0000_0111; wbuf[1] = 32'h0000_0222;
    wr("fixed_wr", 4'd2, 32'h0C, 8'd1, 2'b00, 4'hF, 1'b0, 2'b00);
    check("fixed reg3", 64'(reg_of(3)), 64'h222);
    check("fixed reg4", 64'(reg_of(4)), 64'h0);

    // Reserved burst type: SLVERR, no write, read 0
    wbuf[0] = 32'hFFFF_FFFF;
    wr("badburst_wr", 4'd3, 32'h10, 8'd0, 2'b10, 4'hF, 1'b0, 2'b10);
    check("badburst reg4", 64'(reg_of(4)), 64'h0);
    ed[0] = 32'd0; er[0] = 2'b10;
    rd("badburst_rd", 4'd3, 32'h00, 8'd0, 2'b11, 1'b0);

    // Missing wlast on final beat flags SLVERR but data still commits
    wbuf[0] = 32'h5A5A_5A5A;
    wr("nolast_wr", 4'd4, 32'h04, 8'd0, 2'b01, 4'hF, 1'b1, 2'b10);
    check("nolast reg1", 64'(reg_of(1)), 64'h5A5A_5A5A);

    // Concurrent write/read of reg 2: read samples on the commit edge
    @(negedge clk);
    awid = 4'd3; awaddr = 32'h08; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd9; araddr = 32'h08; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    check("conc wready", 64'(wready), 64'd1);
    check("conc arready", 64'(arready), 64'd1);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check("conc bvalid", 64'(bvalid), 64'd1);
    check("conc rvalid", 64'(rvalid), 64'd1);
    check("conc bid", 64'(bid), 64'd3);
    check("conc rid", 64'(rid), 64'd9);
    check("conc rdata_old", 64'(rdata), 64'd0);
    check("conc reg2", 64'(reg_of(2)), 64'hCAFE_F00D);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    ed[0] = 32'hCAFE_F00D; er[0] = 2'b00;
    rd("conc_rd2", 4'd9, 32'h08, 8'd0, 2'b01, 1'b0);

    // Reset during W_DATA beat 2 of 4
    @(negedge clk);
    awid = 4'd1; awaddr = 32'h00; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wstrb = 4'hF; wvalid = 1'b1;
    wdata = 32'hAAAA; @(posedge clk); @(negedge clk);
    wdata = 32'hBBBB; @(posedge clk); @(negedge clk);
    wdata = 32'hCCCC;
    #2 areset = 1'b0;
    #1;
    check("mid bvalid", 64'(bvalid), 64'd0);
    check("mid rvalid", 64'(rvalid), 64'd0);
    check("mid awready", 64'(awready), 64'd1);
    check("mid wready", 64'(wready), 64'd0);
    check("mid regs", 64'(regs_o == '0), 64'd1);
    @(negedge clk);
    wvalid = 1'b0; areset = 1'b1;
    wbuf[0] = 32'h600D_CAFE;
    wr("post_wr", 4'd6, 32'h18, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
    ed[0] = 32'h600D_CAFE; er[0] = 2'b00;
    rd("post_rd", 4'd6, 32'h18, 8'd0, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/axi_reg_bank.md
Name: axi_reg_bank

Overview:
- Parametrised AXI4 slave register bank. Successor to the fixed 8×32 single-beat register slave.
- Adds configurable width, depth and ID width; FIXED/INCR bursts (LEN up to 256 beats); OKAY/SLVERR responses; a read-only XOR checksum register at index DEPTH; and a flat register image output for fabric logic.
- Sits behind the AXI interconnect as a control/status register block.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8, ≥ 8.
- ADDR_WIDTH, 32, byte-address width.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 8, number of RW registers; ≥ 1.
- RESET_VALUE, 0, reset contents of every register.

Ports:
- clk  in  1  clock.
- areset  in  1  asynchronous, active-low reset.
- awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address channel.
- awvalid  in  1 ; awready  out  1.
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- wvalid  in  1 ; wready  out  1.
- bid/bresp  out  ID_WIDTH/2  write response.
- bvalid  out  1 ; bready  in  1.
- arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address channel.
- arvalid  in  1 ; arready  out  1.
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel.
- rvalid  out  1 ; rready  in  1.
- regs_o  out  DEPTH*DATA_WIDTH  register image; reg k at bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Word index = addr >> log2(DATA_WIDTH/8); low address bits are ignored.
- Index decode:
  - Index < DEPTH: RW register.
  - Index == DEPTH: checksum (XOR of all registers). Read-only; a write beat to it is SLVERR with no effect.
  - Index > DEPTH: SLVERR; reads return 0.
- Burst types: FIXED (00) holds the index; INCR (01) adds 1 per beat. Any other type: every beat is SLVERR, no register is written, reads return 0.
- The beat count is the LEN field + 1. Indices are evaluated per beat, so an INCR burst running past DEPTH gets SLVERR only on the out-of-range beats.
- Reset values:
  - Registers = RESET_VALUE.
  - bvalid = rvalid = rlast = 0; bresp = rresp = 0; bid = rid = 0; rdata = 0.
  - Both FSMs in IDLE, so awready = arready = 1 and wready = 0.
- Reset asserted mid-burst aborts the burst immediately. The partial writes already committed are kept only until the reset clears registers to RESET_VALUE.
- Write FSM, three states:
  - W_IDLE: awready = 1. On AW handshake, latch id/index/len/burst, clear the error flag, go to W_DATA.
  - W_DATA: wready = 1. Each W handshake commits wdata to the current index, byte lane i enabled by wstrb[i], in the same clock edge. SLVERR beats set the sticky error flag. After len+1 beats, go to W_RESP. wlast does not terminate the burst; wlast present on a non-final beat, or absent on the final beat, sets the error flag.
  - W_RESP: bvalid = 1, bid = latched id, bresp = SLVERR if the error flag is set, else OKAY. On B handshake, return to W_IDLE.
- Write latency: AW handshake at cycle N → wready high at N+1. Final W handshake at M → bvalid at M+1.
- W data arriving before AW is not accepted: wready stays 0 outside W_DATA.
- Read FSM, two states:
  - R_IDLE: arready = 1. On AR handshake, latch the request, register beat 0 data/resp/last, go to R_DATA.
  - R_DATA: rvalid = 1. On each R handshake, either load the next beat on the same edge (rvalid stays high, one beat per cycle) or, after the last beat, return to R_IDLE.
- Read outputs: rlast = 1 only on the final beat; rid = latched id.
- Read latency: AR handshake at N → rvalid at N+1.
- Read data is sampled when the beat register loads. A write committing on that same edge is not visible to it (old value).
- While rvalid && !rready, rdata, rresp and rlast stay stable.
- The read and write FSMs run fully concurrently.
- Checksum and regs_o are combinational from the register array.

Decomposition:
- Package axi_reg_pkg holds:
  - Response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Burst constants BURST_FIXED = 2'b00, BURST_INCR = 2'b01.
  - Enums w_state_t {W_IDLE, W_DATA, W_RESP} and r_state_t {R_IDLE, R_DATA}.
- One combinational sub-module, axi_reg_decode, instantiated twice (write path, read path):
  - Inputs: index, burst.
  - Outputs: is_reg, is_csum, err.

Test Plan:
- DEPTH=8, DATA_WIDTH=32: single write of 0xDEADBEEF to addr 0x08, wstrb=0xF; then read addr 0x08 → bresp OKAY; rdata 0xDEADBEEF, rresp OKAY, rlast=1.
- Partial strobe: reg1 = 0x11223344, then write 0xAABBCCDD with wstrb=0x5 → read returns 0x11BB33DD.
- INCR write burst: awaddr=0x14, awlen=3, data 1,2,3,4 → regs 5,6,7 = 1,2,3; beat 4 hits index 8 (checksum); bresp SLVERR; checksum reads 1^2^3 with all other registers 0.
- INCR read burst: araddr=0, arlen=9, rready toggled 1/0 → 10 beats with data held stable while stalled; beats 0–7 OKAY; beat 8 = checksum, OKAY; beat 9 = 0, SLVERR with rlast=1.
- Concurrency and IDs: awid=3 write to reg 2 overlapping arid=9 read of reg 2 → bid=3, rid=9; read returns the pre-write value when sampled on the same edge as the commit.
- Reset mid-burst: areset low during W_DATA beat 2 of 4 → bvalid/rvalid 0, awready=1, all regs RESET_VALUE; a subsequent single write/read completes OKAY.
